// File: rtl/w_ram_loader_pkg.sv
// Shared sizing macros, row type and FSM encoding for the weight-RAM loader.
// Designs that pair the loader with w_RAM use these same definitions.
`ifndef MAX_DEPTH
`define MAX_DEPTH 2
`endif
`ifndef MAX_NEURONS
`define MAX_NEURONS 4
`endif
`ifndef WORD_W
`define WORD_W 8
`endif

package w_ram_loader_pkg;

    typedef logic [`MAX_NEURONS-1:0][`WORD_W-1:0] ARR;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Non-positive requests load nothing; oversize requests stop at the RAM depth.
    function automatic int clamp_layers(input int cfg, input int max_layers);
        if (cfg <= 0)
            return 0;
        else if (cfg > max_layers)
            return max_layers;
        return cfg;
    endfunction

endpackage

// File: rtl/w_ram_loader.sv
// Streams weight words into a row register and writes each full row into w_RAM,
// walking neuron then layer addresses until the requested number of layers is loaded.
module w_ram_loader
    import w_ram_loader_pkg::*;
#(
    parameter int MAX_DEPTH   = `MAX_DEPTH,
    parameter int MAX_NEURONS = `MAX_NEURONS,
    parameter int WORD_W      = `WORD_W
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                start,
    input  int                                  cfg_layers,
    input  logic                                s_valid,
    input  logic [WORD_W-1:0]                   s_data,
    output logic                                s_ready,
    output logic                                rw,
    output int                                  layer_index,
    output int                                  neuron_index,
    output logic [MAX_NEURONS-1:0][WORD_W-1:0]  w_in,
    output logic                                busy,
    output logic                                done
);

    localparam int CNT_W = (MAX_NEURONS > 1) ? $clog2(MAX_NEURONS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(MAX_NEURONS - 1);

    state_t           state;
    int               layers_q;
    logic [CNT_W-1:0] word_cnt;

    // Strobes decode straight from the state register, so they change only on CLK.
    assign s_ready = (state == COLLECT);
    assign rw      = (state == WRITE);
    assign busy    = (state == COLLECT) || (state == WRITE);
    assign done    = (state == DONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            layers_q     <= 0;
            word_cnt     <= '0;
            layer_index  <= 0;
            neuron_index <= 0;
            w_in         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        layers_q     <= clamp_layers(cfg_layers, MAX_DEPTH);
                        word_cnt     <= '0;
                        layer_index  <= 0;
                        neuron_index <= 0;
                        state        <= (clamp_layers(cfg_layers, MAX_DEPTH) == 0) ? DONE : COLLECT;
                    end
                end
                COLLECT: begin
                    // s_ready is high throughout COLLECT, so s_valid alone marks a transfer.
                    if (s_valid) begin
                        w_in[word_cnt] <= s_data;
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            state    <= WRITE;
                        end else begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    // Addresses advance on the edge that ends the write, after w_RAM has captured the row.
                    if (neuron_index < MAX_NEURONS - 1) begin
                        neuron_index <= neuron_index + 1;
                        state        <= COLLECT;
                    end else if (layer_index < layers_q - 1) begin
                        neuron_index <= 0;
                        layer_index  <= layer_index + 1;
                        state        <= COLLECT;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_w_ram_loader.sv
// Directed bench: loader paired with a behavioural w_RAM, read back after each load.
`timescale 1ns/1ps
module tb_w_ram_loader;

    localparam int MD = 2;
    localparam int MN = 4;
    localparam int WW = 8;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b1;
    logic                   start = 1'b0;
    int                     cfg_layers = 0;
    logic                   s_valid = 1'b0;
    logic [WW-1:0]          s_data = '0;
    logic                   s_ready;
    logic                   rw;
    int                     layer_index;
    int                     neuron_index;
    logic [MN-1:0][WW-1:0]  w_in;
    logic                   busy;
    logic                   done;

    int checks = 0;
    int failures = 0;

    w_ram_loader #(.MAX_DEPTH(MD), .MAX_NEURONS(MN), .WORD_W(WW)) dut (
        .CLK(CLK), .RST(RST), .start(start), .cfg_layers(cfg_layers),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .rw(rw),
        .layer_index(layer_index), .neuron_index(neuron_index), .w_in(w_in),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    // Behavioural w_RAM with a bench-side clear.
    logic        ram_clr = 1'b0;
    logic [31:0] ram [MD][MN];
    always @(posedge CLK) begin
        if (ram_clr) begin
            for (int l = 0; l < MD; l++)
                for (int n = 0; n < MN; n++)
                    ram[l][n] <= '0;
        end else if (rw && layer_index >= 0 && layer_index < MD && neuron_index >= 0 && neuron_index < MN) begin
            ram[layer_index][neuron_index] <= w_in;
        end
    end

    // Event counters and expected-write model: a write follows every 4th transfer by one cycle.
    int   n_rw = 0;
    int   n_done = 0;
    int   n_xfer = 0;
    int   row_pos = 0;
    logic exp_rw = 1'b0;
    always @(posedge CLK) begin
        if (rw) n_rw++;
        if (done) n_done++;
        if (RST) begin
            row_pos = 0;
            exp_rw  = 1'b0;
        end else if (s_valid && s_ready) begin
            n_xfer++;
            exp_rw  = (row_pos == MN - 1);
            row_pos = (row_pos + 1) % MN;
        end else begin
            exp_rw = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (exp_rw || rw) begin
            check("rw_timing", {63'd0, rw}, {63'd0, exp_rw});
            check("ready_in_write", {63'd0, s_ready}, 64'd0);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input int layers);
        start = 1'b1;
        cfg_layers = layers;
        step();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [WW-1:0] w, input bit toggle);
        logic hs;
        hs = 1'b0;
        s_valid = 1'b1;
        s_data = w;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge CLK);
            hs = s_ready;
            step();
        end
        if (!hs) check("send_timeout", 64'd0, 64'd1);
        if (toggle) begin
            s_valid = 1'b0;
            step();
        end
    endtask

    task automatic send_range(input int first, input int last, input bit toggle);
        for (int w = first; w <= last; w++) send_word(WW'(w), toggle);
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            seen = done;
        end
        check("done_seen", {63'd0, seen}, 64'd1);
        step();
    endtask

    task automatic clear_ram();
        ram_clr = 1'b1;
        step();
        ram_clr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rw"}, {63'd0, rw}, 64'd0);
        check({tag, "_ready"}, {63'd0, s_ready}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_layer"}, 64'(layer_index), 64'd0);
        check({tag, "_neuron"}, 64'(neuron_index), 64'd0);
        check({tag, "_w_in"}, {32'd0, w_in}, 64'd0);
    endtask

    int rw0, done0, xfer0;

    initial begin
        // Reset state
        RST = 1'b1;
        clear_ram();
        step();
        step();
        @(negedge CLK);
        check_reset_outputs("reset");
        step();
        RST = 1'b0;
        step();

        // Full load, s_valid held high
        rw0 = n_rw; done0 = n_done; xfer0 = n_xfer;
        do_start(2);
        @(negedge CLK);
        check("full_busy_start", {63'd0, busy}, 64'd1);
        step();
        send_range(1, 10, 1'b0);
        @(negedge CLK);
        check("full_busy_mid", {63'd0, busy}, 64'd1);
        step();
        send_range(11, 32, 1'b0);
        wait_done();
        check("full_rw_count", 64'(n_rw - rw0), 64'd8);
        check("full_done_count", 64'(n_done - done0), 64'd1);
        check("full_xfer_count", 64'(n_xfer - xfer0), 64'd32);
        check("full_row00", {32'd0, ram[0][0]}, {32'd0, 8'd4, 8'd3, 8'd2, 8'd1});
        check("full_row12", {32'd0, ram[1][2]}, {32'd0, 8'd28, 8'd27, 8'd26, 8'd25});
        check("full_row13", {32'd0, ram[1][3]}, {32'd0, 8'd32, 8'd31, 8'd30, 8'd29});
        check("full_busy_end", {63'd0, busy}, 64'd0);
        check("full_layer_hold", 64'(layer_index), 64'd1);
        check("full_neuron_hold", 64'(neuron_index), 64'd3);

        // Backpressure: s_valid toggles every cycle
        clear_ram();
        rw0 = n_rw; xfer0 = n_xfer;
        do_start(2);
        send_range(1, 32, 1'b1);
        wait_done();
        check("bp_rw_count", 64'(n_rw - rw0), 64'd8);
        check("bp_xfer_count", 64'(n_xfer - xfer0), 64'd32);
        check("bp_row01", {32'd0, ram[0][1]}, {32'd0, 8'd8, 8'd7, 8'd6, 8'd5});
        check("bp_row12", {32'd0, ram[1][2]}, {32'd0, 8'd28, 8'd27, 8'd26, 8'd25});
        check("bp_row10", {32'd0, ram[1][0]}, {32'd0, 8'd20, 8'd19, 8'd18, 8'd17});

        // Clamp: 5 layers requested, 2 available
        rw0 = n_rw;
        do_start(5);
        send_range(101, 132, 1'b0);
        wait_done();
        check("clamp_rw_count", 64'(n_rw - rw0), 64'd8);
        check("clamp_row13", {32'd0, ram[1][3]}, {32'd0, 8'd132, 8'd131, 8'd130, 8'd129});
        s_valid = 1'b1;
        step();
        @(negedge CLK);
        check("clamp_idle_ready", {63'd0, s_ready}, 64'd0);
        s_valid = 1'b0;
        step();

        // Zero layers: straight to done, no writes
        rw0 = n_rw; done0 = n_done;
        do_start(0);
        @(negedge CLK);
        check("zero_done_pulse", {63'd0, done}, 64'd1);
        check("zero_busy", {63'd0, busy}, 64'd0);
        step();
        step();
        step();
        check("zero_rw_count", 64'(n_rw - rw0), 64'd0);
        check("zero_done_count", 64'(n_done - done0), 64'd1);

        // Start during COLLECT is ignored
        clear_ram();
        rw0 = n_rw;
        do_start(2);
        send_range(1, 6, 1'b0);
        do_start(1);
        send_range(7, 32, 1'b0);
        wait_done();
        check("ign_rw_count", 64'(n_rw - rw0), 64'd8);
        check("ign_row01", {32'd0, ram[0][1]}, {32'd0, 8'd8, 8'd7, 8'd6, 8'd5});
        check("ign_row13", {32'd0, ram[1][3]}, {32'd0, 8'd32, 8'd31, 8'd30, 8'd29});
        check("ign_layer", 64'(layer_index), 64'd1);

        // Reset after word 10 aborts the load
        clear_ram();
        rw0 = n_rw;
        do_start(2);
        send_range(1, 10, 1'b0);
        RST = 1'b1;
        step();
        @(negedge CLK);
        check_reset_outputs("midrst");
        step();
        RST = 1'b0;
        step();
        step();
        step();
        check("midrst_rw_count", 64'(n_rw - rw0), 64'd2);
        check("midrst_row01", {32'd0, ram[0][1]}, {32'd0, 8'd8, 8'd7, 8'd6, 8'd5});
        check("midrst_row02", {32'd0, ram[0][2]}, 64'd0);
        rw0 = n_rw;
        do_start(1);
        send_range(51, 66, 1'b0);
        wait_done();
        check("reload_rw_count", 64'(n_rw - rw0), 64'd4);
        check("reload_row00", {32'd0, ram[0][0]}, {32'd0, 8'd54, 8'd53, 8'd52, 8'd51});
        check("reload_row03", {32'd0, ram[0][3]}, {32'd0, 8'd66, 8'd65, 8'd64, 8'd63});
        check("reload_layer", 64'(layer_index), 64'd0);
        check("reload_neuron", 64'(neuron_index), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
